// File: rtl/proto_stream_arbiter.sv
// Round-robin frame arbiter: grants whole length-delimited protobuf frames,
// strips the varint length prefix and forwards tagged payload bytes downstream.
module proto_stream_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LEN_BYTES = 4,
  parameter int MAX_LEN   = 4096,
  localparam int SW       = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           stream_data_o,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic                 stream_first_o,
  output logic                 stream_last_o,
  output logic [SW-1:0]        stream_src_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int ACC_W = 7 * LEN_BYTES;
  localparam int RW    = $clog2(MAX_LEN + 1);
  localparam int IW    = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam logic [ACC_W-1:0] MAX_L = ACC_W'(MAX_LEN);

  typedef enum logic [1:0] {ARB, LEN, PAYLOAD, HALT} state_t;

  state_t           state;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    last_grant;
  logic [RW-1:0]    remaining;
  logic [ACC_W-1:0] len_acc;
  logic [IW-1:0]    len_idx;
  logic             first_pend;

  logic [7:0]       cur_byte;
  logic             cur_valid;
  logic             out_free;
  logic [ACC_W-1:0] len_next;
  logic             arb_hit;
  logic [SW-1:0]    arb_sel;

  assign cur_byte  = req_data_i[8*int'(grant) +: 8];
  assign cur_valid = req_valid_i[grant];
  assign out_free  = !stream_valid_o || stream_ready_i;
  assign len_next  = len_acc | (ACC_W'(cur_byte[6:0]) << (7 * int'(len_idx)));

  always_comb begin
    req_ready_o = '0;
    case (state)
      LEN:     req_ready_o[grant] = 1'b1;
      PAYLOAD: req_ready_o[grant] = out_free;
      default: req_ready_o = '0;
    endcase
  end

  // Search order starts one past the last frame owner and wraps.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = last_grant;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      if (!arb_hit && req_valid_i[SW'((32'(last_grant) + off) % NUM_REQ)]) begin
        arb_hit = 1'b1;
        arb_sel = SW'((32'(last_grant) + off) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state          <= ARB;
      grant          <= '0;
      last_grant     <= SW'(NUM_REQ - 1);
      remaining      <= '0;
      len_acc        <= '0;
      len_idx        <= '0;
      first_pend     <= 1'b0;
      stream_data_o  <= '0;
      stream_valid_o <= 1'b0;
      stream_first_o <= 1'b0;
      stream_last_o  <= 1'b0;
      stream_src_o   <= '0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      if (stream_valid_o && stream_ready_i) begin
        stream_valid_o <= 1'b0;
        stream_first_o <= 1'b0;
        stream_last_o  <= 1'b0;
      end
      case (state)
        ARB: begin
          if (arb_hit) begin
            grant   <= arb_sel;
            len_acc <= '0;
            len_idx <= '0;
            busy_o  <= 1'b1;
            state   <= LEN;
          end
        end
        LEN: begin
          if (cur_valid) begin
            if (cur_byte[7]) begin
              if (len_idx == IW'(LEN_BYTES - 1)) begin
                err_o <= 1'b1;
                state <= HALT;
              end else begin
                len_acc <= len_next;
                len_idx <= len_idx + IW'(1);
              end
            end else if (len_next > MAX_L) begin
              err_o <= 1'b1;
              state <= HALT;
            end else if (len_next == '0) begin
              last_grant <= grant;
              busy_o     <= 1'b0;
              state      <= ARB;
            end else begin
              remaining  <= RW'(len_next);
              first_pend <= 1'b1;
              state      <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          // first_pend stands in for "remaining still equals the frame length".
          if (cur_valid && out_free) begin
            stream_data_o  <= cur_byte;
            stream_valid_o <= 1'b1;
            stream_first_o <= first_pend;
            stream_last_o  <= (remaining == RW'(1));
            stream_src_o   <= grant;
            remaining      <= remaining - RW'(1);
            first_pend     <= 1'b0;
            if (remaining == RW'(1)) begin
              last_grant <= grant;
              busy_o     <= 1'b0;
              state      <= ARB;
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_proto_stream_arbiter.sv
// Directed bench for proto_stream_arbiter with a frame-level round-robin model
// and a per-cycle output scoreboard.
module tb_proto_stream_arbiter;
  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           reset_ni = 1'b0;
  logic [N*8-1:0] req_data_i = '0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [7:0]     stream_data_o;
  logic           stream_valid_o;
  logic           stream_ready_i = 1'b1;
  logic           stream_first_o;
  logic           stream_last_o;
  logic [1:0]     stream_src_o;
  logic           busy_o;
  logic           err_o;

  proto_stream_arbiter #(.NUM_REQ(N), .LEN_BYTES(4), .MAX_LEN(4096)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .stream_data_o(stream_data_o), .stream_valid_o(stream_valid_o),
    .stream_ready_i(stream_ready_i), .stream_first_o(stream_first_o),
    .stream_last_o(stream_last_o), .stream_src_o(stream_src_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
    logic [1:0] s;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bq[N][$];
  logic [7:0] pq[N][$];
  int         fl[N][$];
  int         first_srcs[$];
  int         model_last;
  int         tests = 0, fails = 0;
  int         n_bytes, n_first, n_last;
  logic [7:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic refresh();
    for (int r = 0; r < N; r++) begin
      req_valid_i[r] = (bq[r].size() > 0);
      req_data_i[r*8 +: 8] = (bq[r].size() > 0) ? bq[r][0] : 8'h00;
    end
  endtask

  // Byte-stream requesters: hold valid while bytes remain, pop on handshake.
  initial begin
    logic [N-1:0] fired;
    forever begin
      @(negedge clk_i);
      fired = req_valid_i & req_ready_o;
      @(posedge clk_i);
      #1;
      for (int r = 0; r < N; r++)
        if (fired[r] && bq[r].size() > 0) void'(bq[r].pop_front());
      refresh();
    end
  end

  // Model: varint-encode the length, queue the payload for frame-level scheduling.
  task automatic add_frame(input int r, input logic [7:0] pl[$]);
    int unsigned l;
    logic [7:0] b;
    l = pl.size();
    do begin
      b = 8'(l & 32'h7F);
      l = l >> 7;
      if (l != 0) b[7] = 1'b1;
      bq[r].push_back(b);
    end while (l != 0);
    foreach (pl[i]) begin
      bq[r].push_back(pl[i]);
      pq[r].push_back(pl[i]);
    end
    fl[r].push_back(pl.size());
  endtask

  task automatic model_schedule();
    bit any;
    exp_t e;
    int len;
    int r;
    do begin
      any = 0;
      for (int off = 1; off <= N && !any; off++) begin
        r = (model_last + off) % N;
        if (fl[r].size() > 0) begin
          any = 1;
          len = fl[r].pop_front();
          for (int i = 0; i < len; i++) begin
            e.d = pq[r].pop_front();
            e.f = (i == 0);
            e.l = (i == len - 1);
            e.s = 2'(r);
            exp_q.push_back(e);
          end
          model_last = r;
        end
      end
    end while (any);
  endtask

  // Scoreboard: every output transfer must match the next model entry.
  initial begin
    exp_t e;
    logic hold_prev = 1'b0;
    logic [11:0] prev = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        hold_prev = 1'b0;
      end else begin
        check("ready_onehot", 32'($onehot0(req_ready_o)), 32'd1);
        if (hold_prev)
          check("hold_stable", {stream_valid_o, stream_data_o, stream_first_o, stream_last_o, stream_src_o},
                {1'b1, prev});
        if (stream_valid_o && stream_ready_i) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got 0x%0h expected no output at %0t", stream_data_o, $time);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", {stream_data_o, stream_first_o, stream_last_o, stream_src_o}, e);
          end
          n_bytes++;
          if (stream_first_o) begin
            n_first++;
            first_srcs.push_back(int'(stream_src_o));
          end
          if (stream_last_o) n_last++;
          last_data = stream_data_o;
        end
        hold_prev = stream_valid_o && !stream_ready_i;
        prev = {stream_data_o, stream_first_o, stream_last_o, stream_src_o};
      end
    end
  end

  task automatic clear_counts();
    n_bytes = 0;
    n_first = 0;
    n_last = 0;
    first_srcs.delete();
  endtask

  task automatic reset_assert();
    @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    stream_ready_i = 1'b1;
    for (int r = 0; r < N; r++) begin
      bq[r].delete();
      pq[r].delete();
      fl[r].delete();
    end
    exp_q.delete();
    model_last = N - 1;
    refresh();
    repeat (2) @(negedge clk_i);
  endtask

  task automatic reset_release();
    @(posedge clk_i);
    #2;
    reset_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    bit done;
    k = 0;
    done = 0;
    while (k < budget && !done) begin
      @(negedge clk_i);
      done = (exp_q.size() == 0) && !stream_valid_o;
      for (int r = 0; r < N; r++) if (bq[r].size() != 0) done = 0;
      k++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_err(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !err_o) begin
      @(negedge clk_i);
      k++;
    end
    check(name, 32'(err_o), 32'd1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] held;
    int k;
    model_last = N - 1;
    clear_counts();

    // Reset state.
    @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_stream", {stream_valid_o, stream_data_o, stream_first_o, stream_last_o, stream_src_o}, 32'd0);
    check("rst_busy_err", {busy_o, err_o}, 32'd0);
    reset_release();

    // Single frame on requester 0 with literal timing.
    q = '{8'hA1, 8'hB2, 8'hC3};
    add_frame(0, q);
    model_schedule();
    k = 0;
    while (k < 20 && !(req_valid_i[0] && req_ready_o[0] && req_data_i[7:0] == 8'hA1)) begin
      @(negedge clk_i);
      k++;
    end
    check("t1_accept_a1", 32'(k < 20), 32'd1);
    @(negedge clk_i);
    check("t1_a1", {stream_valid_o, stream_data_o, stream_first_o, stream_last_o, stream_src_o, busy_o},
          {1'b1, 8'hA1, 1'b1, 1'b0, 2'd0, 1'b1});
    @(negedge clk_i);
    check("t1_b2", {stream_valid_o, stream_data_o, stream_first_o, stream_last_o}, {1'b1, 8'hB2, 2'b00});
    @(negedge clk_i);
    check("t1_c3", {stream_valid_o, stream_data_o, stream_first_o, stream_last_o}, {1'b1, 8'hC3, 2'b01});
    check("t1_busy_fall", 32'(busy_o), 32'd0);
    wait_idle("t1_idle", 50);

    // Round-robin order from reset, then wrap past the previous owner.
    reset_assert();
    clear_counts();
    q = '{8'h11, 8'h12};
    add_frame(1, q);
    q = '{8'h21, 8'h22};
    add_frame(2, q);
    model_schedule();
    reset_release();
    wait_idle("t2a_idle", 50);
    q = '{8'h13, 8'h14};
    add_frame(1, q);
    q = '{8'h31, 8'h32};
    add_frame(3, q);
    model_schedule();
    wait_idle("t2b_idle", 50);
    check("t2_nframes", 32'(first_srcs.size()), 32'd4);
    if (first_srcs.size() == 4) begin
      check("t2_order0", 32'(first_srcs[0]), 32'd1);
      check("t2_order1", 32'(first_srcs[1]), 32'd2);
      check("t2_order2", 32'(first_srcs[2]), 32'd3);
      check("t2_order3", 32'(first_srcs[3]), 32'd1);
    end

    // Two-byte varint prefix: 130 payload bytes.
    clear_counts();
    q.delete();
    for (int i = 0; i < 130; i++) q.push_back(8'(i * 7 + 3));
    add_frame(0, q);
    model_schedule();
    wait_idle("t3_idle", 400);
    check("t3_bytes", 32'(n_bytes), 32'd130);
    check("t3_first", 32'(n_first), 32'd1);
    check("t3_last", 32'(n_last), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);

    // Zero-length frame followed by a one-byte frame.
    clear_counts();
    q.delete();
    add_frame(1, q);
    q = '{8'h55};
    add_frame(1, q);
    model_schedule();
    wait_idle("t4_idle", 50);
    check("t4_bytes", 32'(n_bytes), 32'd1);
    check("t4_flags", {n_first[7:0], n_last[7:0]}, 32'h0101);
    check("t4_data", 32'(last_data), 32'h55);

    // Downstream stall mid-frame.
    clear_counts();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'(8'h40 + i));
    add_frame(2, q);
    model_schedule();
    k = 0;
    while (k < 50 && n_bytes < 5) begin
      @(negedge clk_i);
      k++;
    end
    check("t5_reach_mid", 32'(n_bytes >= 5), 32'd1);
    @(posedge clk_i);
    #2;
    stream_ready_i = 1'b0;
    held = stream_data_o;
    repeat (5) begin
      @(negedge clk_i);
      check("t5_stall_data", {stream_valid_o, stream_data_o}, {1'b1, held});
      check("t5_stall_ready", 32'(req_ready_o), 32'd0);
    end
    @(posedge clk_i);
    #2;
    stream_ready_i = 1'b1;
    wait_idle("t5_idle", 100);
    check("t5_bytes", 32'(n_bytes), 32'd20);

    // Over-long varint prefix.
    reset_assert();
    reset_release();
    bq[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    wait_err("t6_err_ff", 30);
    check("t6_ff_consumed", 32'(bq[0].size()), 32'd1);
    bq[2] = '{8'h01, 8'h02};
    repeat (5) begin
      @(negedge clk_i);
      check("t6_halt_ready", 32'(req_ready_o), 32'd0);
    end
    check("t6_err_sticky", 32'(err_o), 32'd1);

    // Length 5000 exceeds the maximum.
    reset_assert();
    check("t6_err_reset", 32'(err_o), 32'd0);
    reset_release();
    bq[0] = '{8'h88, 8'h27, 8'h00};
    wait_err("t6_err_5000", 30);
    check("t6_5000_consumed", 32'(bq[0].size()), 32'd1);

    // Reset restarts arbitration at requester 0.
    reset_assert();
    reset_release();
    check("t6_err_cleared", 32'(err_o), 32'd0);
    clear_counts();
    q = '{8'h61, 8'h62};
    add_frame(1, q);
    q = '{8'h01};
    add_frame(0, q);
    model_schedule();
    wait_idle("t6_idle", 50);
    check("t6_resume_first", 32'(first_srcs.size() > 0 ? first_srcs[0] : -1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
